// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the status-flag synchronous FIFO.
// Pointer width carries one extra wrap bit above the address bits.
package fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_LEVEL  = 2;
  localparam int DEF_AF_MARGIN = 2;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read port.
// The array itself is never reset; only the read register is.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-before-write: a full-FIFO read+write to one slot sees the old word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_status.sv
// Synchronous FIFO with occupancy count and full/empty/almost flags.
// Define SYNC_FIFO_ERR_EN for sticky overflow/underflow with err_clr.
module sync_fifo_status
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  localparam int CW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] wr_ptr_d, wr_ptr_q;
  logic [CW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          rd_valid_d, rd_valid_q;
  logic          rd_acc;
  logic          wr_acc;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign rd_valid     = rd_valid_q;

  // A read frees a slot, so a full FIFO may still take a same-cycle write.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    unique case (1'b1)
      (wr_acc && !rd_acc): count_d = count_q + ONE;
      (rd_acc && !wr_acc): count_d = count_q - ONE;
      default:             count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_d, ovf_q;
  logic unf_d, unf_q;

  // Set beats a same-cycle clear so no error event is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && !wr_acc) begin
      ovf_d = 1'b1;
    end
    if (rd_en && empty) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_status.sv
// Scoreboard bench for sync_fifo_status (WIDTH=8, DEPTH=16, AF=14, AE=2).
// Error-flag checks are built only when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_status;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       overflow, underflow;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mq[$];
  logic [7:0] eq[$];
  logic [7:0] last_rd = '0;
  int max_cnt = 0;

  always #5 clk = ~clk;

  sync_fifo_status #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_flags();
    int n;
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == 16));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    if (32'(count) > max_cnt) max_cnt = 32'(count);
  endtask

  // One clock of stimulus; the model decides what the FIFO must accept.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    bit ra, wa;
    logic [7:0] popped;
    popped = '0;
    wr_en = w;
    wr_data = d;
    rd_en = r;
    ra = r && (mq.size() > 0);
    wa = w && ((mq.size() < 16) || ra);
    if (ra) popped = mq.pop_front();
    if (wa) mq.push_back(d);
    @(posedge clk);
    #1;
    if (ra) begin
      eq.push_back(popped);
      last_rd = popped;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_flags();
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (eq.size() == 0) begin
        chk("unexpected_rd_valid", 32'(rd_valid), 32'(0));
      end else begin
        chk("rd_data", 32'(rd_data), 32'(eq.pop_front()));
      end
    end
  end

  initial begin
    #12;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_ae", 32'(almost_empty), 32'(1));
    chk("rst_af", 32'(almost_full), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(full), 32'(1));
    chk("fill_count", 32'(count), 32'(16));

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b1);
      chk("rw_full_stays", 32'(full), 32'(1));
    end
    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1);

    step(1'b1, 8'hA5, 1'b1);
    chk("empty_rw_count", 32'(count), 32'(1));
    chk("empty_rw_no_valid", 32'(rd_valid), 32'(0));
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("rd_data_hold", 32'(rd_data), 32'(last_rd));
    chk("hold_no_valid", 32'(rd_valid), 32'(0));

    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h30 + i), ((i % 4) != 3) && (i > 2));
    end
    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1);
    chk("wrap_max_count_le16", 32'(max_cnt <= 16), 32'(1));

`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    err_clr = 1'b0;
    chk("clr_overflow", 32'(overflow), 32'(0));
    chk("clr_underflow", 32'(underflow), 32'(0));
    while (mq.size() < 16) step(1'b1, 8'(8'h60 + mq.size()), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    chk("overflow_set", 32'(overflow), 32'(1));
    chk("overflow_count", 32'(count), 32'(16));
    err_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    err_clr = 1'b0;
    chk("overflow_cleared", 32'(overflow), 32'(0));
    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1);
    chk("underflow_pre", 32'(underflow), 32'(0));
    step(1'b0, 8'h00, 1'b1);
    chk("underflow_set", 32'(underflow), 32'(1));
`endif

    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("pre_reset_count", 32'(count), 32'(7));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty), 32'(1));
    chk("mid_rst_count", 32'(count), 32'(0));
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("mid_rst_full", 32'(full), 32'(0));
    mq.delete();
    eq.delete();
    #1 rst_n = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_word", 32'(rd_data), 32'(8'h77));

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(eq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
